// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
module dcache_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 3,
  parameter int OFF_W  = 2
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              READ,
  input  logic                              WRITE,
  input  logic [ADDR_W-1:0]                 ADDRESS,
  input  logic [DATA_W-1:0]                 WRITEDATA,
  output logic [DATA_W-1:0]                 READDATA,
  output logic                              BUSYWAIT,
  output logic                              MEM_READ,
  output logic                              MEM_WRITE,
  output logic [ADDR_W-OFF_W-1:0]           MEM_ADDRESS,
  output logic [DATA_W*(2**OFF_W)-1:0]      MEM_WRITEDATA,
  input  logic [DATA_W*(2**OFF_W)-1:0]      MEM_READDATA,
  input  logic                              MEM_BUSYWAIT
);

  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int NBLK  = 2**IDX_W;
  localparam int BLK_W = DATA_W * (2**OFF_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE_BACK,
    ST_MEM_READ
  } state_t;

  state_t state;
  state_t state_next;

  // Data and tag arrays carry no reset; valid/dirty alone decide what is live.
  logic [BLK_W-1:0] data_arr [NBLK];
  logic [TAG_W-1:0] tag_arr  [NBLK];
  logic [NBLK-1:0]  valid_arr;
  logic [NBLK-1:0]  dirty_arr;

  logic [TAG_W-1:0] addr_tag;
  logic [IDX_W-1:0] addr_idx;
  logic [OFF_W-1:0] addr_off;
  logic             hit;
  logic             req;
  logic             write_hit;
  logic             fill_done;

  assign addr_tag  = ADDRESS[ADDR_W-1 -: TAG_W];
  assign addr_idx  = ADDRESS[OFF_W +: IDX_W];
  assign addr_off  = ADDRESS[OFF_W-1:0];
  assign hit       = valid_arr[addr_idx] && (tag_arr[addr_idx] == addr_tag);
  assign req       = READ || WRITE;
  // A simultaneous READ and WRITE is treated as a store.
  assign write_hit = (state == ST_IDLE) && WRITE && hit;
  // The refill lands on the edge where memory drops its busy flag.
  assign fill_done = (state == ST_MEM_READ) && !MEM_BUSYWAIT;

  // State register; reset abandons any in-flight memory transaction.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Valid/dirty bookkeeping: refill makes a block valid and clean, a store hit dirties it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_arr <= '0;
      dirty_arr <= '0;
    end else if (fill_done) begin
      valid_arr[addr_idx] <= 1'b1;
      dirty_arr[addr_idx] <= 1'b0;
    end else if (write_hit) begin
      dirty_arr[addr_idx] <= 1'b1;
    end
  end

  // Data/tag storage: whole-block refill from memory or single-byte store on a hit.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (fill_done) begin
        data_arr[addr_idx] <= MEM_READDATA;
        tag_arr[addr_idx]  <= addr_tag;
      end else if (write_hit) begin
        data_arr[addr_idx][int'(addr_off)*DATA_W +: DATA_W] <= WRITEDATA;
      end
    end
  end

  // Next-state and output decode; hits complete combinationally with no stall.
  always_comb begin
    state_next    = state;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    READDATA      = '0;
    case (state)
      ST_IDLE: begin
        if (hit) begin
          READDATA = data_arr[addr_idx][int'(addr_off)*DATA_W +: DATA_W];
        end
        if (req && !hit) begin
          BUSYWAIT = 1'b1;
          if (valid_arr[addr_idx] && dirty_arr[addr_idx]) begin
            state_next = ST_WRITE_BACK;
          end else begin
            state_next = ST_MEM_READ;
          end
        end
      end
      ST_WRITE_BACK: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_arr[addr_idx], addr_idx};
        MEM_WRITEDATA = data_arr[addr_idx];
        if (!MEM_BUSYWAIT) begin
          state_next = ST_MEM_READ;
        end
      end
      ST_MEM_READ: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {addr_tag, addr_idx};
        if (!MEM_BUSYWAIT) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed self-checking bench for dcache_ctrl
module tb_dcache_ctrl;

  logic        CLK;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  int assertions = 0;
  int failures   = 0;

  logic [31:0] mem [64];
  int          mem_busy = 5;
  int          mem_cnt  = 0;

  dcache_ctrl dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .READ         (READ),
    .WRITE        (WRITE),
    .ADDRESS      (ADDRESS),
    .WRITEDATA    (WRITEDATA),
    .READDATA     (READDATA),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_WRITE    (MEM_WRITE),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Block memory: mem_busy busy cycles, then one ready cycle that completes the op.
  always @(negedge CLK) begin
    if (MEM_READ || MEM_WRITE) begin
      if (mem_cnt < mem_busy) begin
        MEM_BUSYWAIT = 1'b1;
        mem_cnt++;
      end else begin
        MEM_BUSYWAIT = 1'b0;
        mem_cnt = 0;
        if (MEM_WRITE) mem[MEM_ADDRESS] = MEM_WRITEDATA;
        else           MEM_READDATA = mem[MEM_ADDRESS];
      end
    end else begin
      MEM_BUSYWAIT = 1'b0;
      mem_cnt = 0;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_miss(output int cyc, output logic saw_wr, output logic [5:0] wr_addr,
                          output logic [31:0] wr_data, output logic [5:0] rd_addr,
                          output logic overlap);
    logic saw_rd;
    cyc = 0; saw_wr = 0; saw_rd = 0; wr_addr = '0; wr_data = '0; rd_addr = '0; overlap = 0;
    while (BUSYWAIT && cyc < 200) begin
      step();
      cyc++;
      if (MEM_READ && MEM_WRITE) overlap = 1'b1;
      if (MEM_WRITE && !saw_wr) begin
        saw_wr = 1'b1; wr_addr = MEM_ADDRESS; wr_data = MEM_WRITEDATA;
      end
      if (MEM_READ && !saw_rd) begin
        saw_rd = 1'b1; rd_addr = MEM_ADDRESS;
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
    assertions++; if (BUSYWAIT !== 1'b0) begin failures++; $display("FAIL reset_busywait: got %b expected 0", BUSYWAIT); end
    assertions++; if (MEM_READ !== 1'b0) begin failures++; $display("FAIL reset_mem_read: got %b expected 0", MEM_READ); end
    assertions++; if (MEM_WRITE !== 1'b0) begin failures++; $display("FAIL reset_mem_write: got %b expected 0", MEM_WRITE); end
    assertions++; if (MEM_ADDRESS !== 6'h00) begin failures++; $display("FAIL reset_mem_address: got %h expected 00", MEM_ADDRESS); end
    assertions++; if (MEM_WRITEDATA !== 32'h0) begin failures++; $display("FAIL reset_mem_writedata: got %h expected 0", MEM_WRITEDATA); end
    assertions++; if (READDATA !== 8'h00) begin failures++; $display("FAIL reset_readdata: got %h expected 00", READDATA); end
  endtask

  task automatic test_clean_miss();
    int cyc; logic sw; logic [5:0] wa; logic [31:0] wd; logic [5:0] ra; logic ov;
    ADDRESS = 8'h00; READ = 1'b1;
    #1;
    assertions++; if (BUSYWAIT !== 1'b1) begin failures++; $display("FAIL miss_busywait: got %b expected 1", BUSYWAIT); end
    assertions++; if (READDATA !== 8'h00) begin failures++; $display("FAIL miss_readdata_zero: got %h expected 00", READDATA); end
    run_miss(cyc, sw, wa, wd, ra, ov);
    assertions++; if (ra !== 6'h00) begin failures++; $display("FAIL miss_mem_address: got %h expected 00", ra); end
    assertions++; if (sw !== 1'b0) begin failures++; $display("FAIL miss_no_writeback: got %b expected 0", sw); end
    assertions++; if (cyc != 7) begin failures++; $display("FAIL miss_latency: got %0d expected 7", cyc); end
    assertions++; if (READDATA !== 8'h11) begin failures++; $display("FAIL miss_readdata: got %h expected 11", READDATA); end
    ADDRESS = 8'h03;
    #1;
    assertions++; if (BUSYWAIT !== 1'b0) begin failures++; $display("FAIL hit_busywait: got %b expected 0", BUSYWAIT); end
    assertions++; if (READDATA !== 8'h44) begin failures++; $display("FAIL hit_readdata: got %h expected 44", READDATA); end
    step();
  endtask

  task automatic test_write_hit();
    READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h01; WRITEDATA = 8'hAB;
    #1;
    assertions++; if (BUSYWAIT !== 1'b0) begin failures++; $display("FAIL wr_hit_busywait: got %b expected 0", BUSYWAIT); end
    assertions++; if ({MEM_READ, MEM_WRITE} !== 2'b00) begin failures++; $display("FAIL wr_hit_mem_idle: got %b expected 00", {MEM_READ, MEM_WRITE}); end
    step();
    WRITE = 1'b0; READ = 1'b1; ADDRESS = 8'h01;
    #1;
    assertions++; if (READDATA !== 8'hAB) begin failures++; $display("FAIL wr_hit_readback: got %h expected ab", READDATA); end
    assertions++; if (BUSYWAIT !== 1'b0) begin failures++; $display("FAIL rd_after_wr_busywait: got %b expected 0", BUSYWAIT); end
    step();
  endtask

  task automatic test_dirty_evict();
    int cyc; logic sw; logic [5:0] wa; logic [31:0] wd; logic [5:0] ra; logic ov;
    READ = 1'b1; ADDRESS = 8'h21;
    #1;
    assertions++; if (BUSYWAIT !== 1'b1) begin failures++; $display("FAIL evict_busywait: got %b expected 1", BUSYWAIT); end
    run_miss(cyc, sw, wa, wd, ra, ov);
    assertions++; if (sw !== 1'b1) begin failures++; $display("FAIL evict_saw_write: got %b expected 1", sw); end
    assertions++; if (wa !== 6'h00) begin failures++; $display("FAIL evict_wb_address: got %h expected 00", wa); end
    assertions++; if (wd !== 32'h4433AB11) begin failures++; $display("FAIL evict_wb_data: got %h expected 4433ab11", wd); end
    assertions++; if (ra !== 6'h08) begin failures++; $display("FAIL evict_rd_address: got %h expected 08", ra); end
    assertions++; if (ov !== 1'b0) begin failures++; $display("FAIL evict_overlap: got %b expected 0", ov); end
    assertions++; if (cyc != 13) begin failures++; $display("FAIL evict_latency: got %0d expected 13", cyc); end
    assertions++; if (READDATA !== 8'h66) begin failures++; $display("FAIL evict_readdata: got %h expected 66", READDATA); end
    assertions++; if (mem[0] !== 32'h4433AB11) begin failures++; $display("FAIL evict_mem_image: got %h expected 4433ab11", mem[0]); end
    step();
    READ = 1'b0;
  endtask

  task automatic test_write_allocate();
    int cyc; logic sw; logic [5:0] wa; logic [31:0] wd; logic [5:0] ra; logic ov;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    WRITE = 1'b1; ADDRESS = 8'hFE; WRITEDATA = 8'h5A;
    #1;
    assertions++; if (BUSYWAIT !== 1'b1) begin failures++; $display("FAIL alloc_busywait: got %b expected 1", BUSYWAIT); end
    run_miss(cyc, sw, wa, wd, ra, ov);
    assertions++; if (ra !== 6'h3F) begin failures++; $display("FAIL alloc_rd_address: got %h expected 3f", ra); end
    assertions++; if (sw !== 1'b0) begin failures++; $display("FAIL alloc_no_writeback: got %b expected 0", sw); end
    assertions++; if (cyc != 7) begin failures++; $display("FAIL alloc_latency: got %0d expected 7", cyc); end
    step();
    WRITE = 1'b0; READ = 1'b1; ADDRESS = 8'hFE;
    #1;
    assertions++; if (READDATA !== 8'h5A) begin failures++; $display("FAIL alloc_readback: got %h expected 5a", READDATA); end
    step();
    ADDRESS = 8'h1E;
    #1;
    run_miss(cyc, sw, wa, wd, ra, ov);
    assertions++; if (wa !== 6'h3F) begin failures++; $display("FAIL alloc_wb_address: got %h expected 3f", wa); end
    assertions++; if (wd !== 32'hDD5ABBAA) begin failures++; $display("FAIL alloc_wb_data: got %h expected dd5abbaa", wd); end
    assertions++; if (ra !== 6'h07) begin failures++; $display("FAIL alloc_evict_rd_address: got %h expected 07", ra); end
    assertions++; if (cyc != 13) begin failures++; $display("FAIL alloc_evict_latency: got %0d expected 13", cyc); end
    assertions++; if (READDATA !== 8'h0E) begin failures++; $display("FAIL alloc_evict_readdata: got %h expected 0e", READDATA); end
    step();
  endtask

  task automatic test_reset_mid_fill();
    int cyc; logic sw; logic [5:0] wa; logic [31:0] wd; logic [5:0] ra; logic ov;
    READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h1C; WRITEDATA = 8'h99;
    #1;
    assertions++; if (BUSYWAIT !== 1'b0) begin failures++; $display("FAIL rst_dirty_hit_busywait: got %b expected 0", BUSYWAIT); end
    step();
    WRITE = 1'b0; READ = 1'b1; ADDRESS = 8'h00;
    step();
    step();
    assertions++; if (MEM_READ !== 1'b1) begin failures++; $display("FAIL rst_pre_mem_read: got %b expected 1", MEM_READ); end
    assertions++; if (MEM_BUSYWAIT !== 1'b1) begin failures++; $display("FAIL rst_pre_mem_busy: got %b expected 1", MEM_BUSYWAIT); end
    RESET = 1'b1; READ = 1'b0;
    step();
    RESET = 1'b0;
    assertions++; if (MEM_READ !== 1'b0) begin failures++; $display("FAIL rst_mem_read_drop: got %b expected 0", MEM_READ); end
    assertions++; if (BUSYWAIT !== 1'b0) begin failures++; $display("FAIL rst_busywait: got %b expected 0", BUSYWAIT); end
    READ = 1'b1; ADDRESS = 8'h1C;
    #1;
    assertions++; if (BUSYWAIT !== 1'b1) begin failures++; $display("FAIL rst_valid_cleared: got %b expected 1", BUSYWAIT); end
    run_miss(cyc, sw, wa, wd, ra, ov);
    assertions++; if (sw !== 1'b0) begin failures++; $display("FAIL rst_dirty_discarded: got %b expected 0", sw); end
    assertions++; if (cyc != 7) begin failures++; $display("FAIL rst_refill_latency: got %0d expected 7", cyc); end
    assertions++; if (READDATA !== 8'h0C) begin failures++; $display("FAIL rst_refill_readdata: got %h expected 0c", READDATA); end
    step();
    ADDRESS = 8'h00;
    #1;
    assertions++; if (BUSYWAIT !== 1'b1) begin failures++; $display("FAIL rst_idx0_miss: got %b expected 1", BUSYWAIT); end
    run_miss(cyc, sw, wa, wd, ra, ov);
    assertions++; if (cyc != 7) begin failures++; $display("FAIL rst_idx0_latency: got %0d expected 7", cyc); end
    assertions++; if (READDATA !== 8'h11) begin failures++; $display("FAIL rst_idx0_readdata: got %h expected 11", READDATA); end
    step();
  endtask

  task automatic test_read_write_together();
    int cyc; logic sw; logic [5:0] wa; logic [31:0] wd; logic [5:0] ra; logic ov;
    READ = 1'b1; WRITE = 1'b1; ADDRESS = 8'h02; WRITEDATA = 8'h77;
    #1;
    assertions++; if (BUSYWAIT !== 1'b0) begin failures++; $display("FAIL rw_busywait: got %b expected 0", BUSYWAIT); end
    step();
    assertions++; if ({MEM_READ, MEM_WRITE} !== 2'b00) begin failures++; $display("FAIL rw_no_mem_traffic: got %b expected 00", {MEM_READ, MEM_WRITE}); end
    WRITE = 1'b0;
    #1;
    assertions++; if (READDATA !== 8'h77) begin failures++; $display("FAIL rw_byte_updated: got %h expected 77", READDATA); end
    step();
    ADDRESS = 8'h22;
    #1;
    run_miss(cyc, sw, wa, wd, ra, ov);
    assertions++; if (sw !== 1'b1) begin failures++; $display("FAIL rw_dirty_set: got %b expected 1", sw); end
    assertions++; if (wd !== 32'h4477AB11) begin failures++; $display("FAIL rw_wb_data: got %h expected 4477ab11", wd); end
    assertions++; if (ra !== 6'h08) begin failures++; $display("FAIL rw_rd_address: got %h expected 08", ra); end
    assertions++; if (READDATA !== 8'h77) begin failures++; $display("FAIL rw_refill_readdata: got %h expected 77", READDATA); end
    step();
    READ = 1'b0;
  endtask

  initial begin
    RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    MEM_READDATA = '0; MEM_BUSYWAIT = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[6'h00] = 32'h44332211;
    mem[6'h08] = 32'h88776655;
    mem[6'h3F] = 32'hDDCCBBAA;
    mem[6'h07] = 32'h0F0E0D0C;
    test_reset();
    test_clean_miss();
    test_write_hit();
    test_dirty_evict();
    test_write_allocate();
    test_reset_mid_fill();
    test_read_write_together();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache between the ALU and the data memory.
- The ALU RESULT drives ADDRESS for load/store instructions. READDATA feeds the register-file write mux.
- BUSYWAIT stalls the PC and register-file writes until the access completes.
- The backing memory is word-block organised, with a multi-cycle busywait handshake.

Parameters:
- ADDR_W, 8, CPU byte-address width.
- DATA_W, 8, CPU word width.
- IDX_W, 3, index bits; the cache holds 2**IDX_W = 8 blocks.
- OFF_W, 2, offset bits; each block holds 2**OFF_W = 4 bytes, so the memory word is 32 bits.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- READ  in  1  CPU load request, held until BUSYWAIT=0.
- WRITE  in  1  CPU store request, held until BUSYWAIT=0.
- ADDRESS  in  8  byte address {tag[2:0], index[2:0], offset[1:0]}.
- WRITEDATA  in  8  store data.
- READDATA  out  8  load data.
- BUSYWAIT  out  1  CPU stall.
- MEM_READ  out  1  memory block read request.
- MEM_WRITE  out  1  memory block write request.
- MEM_ADDRESS  out  6  block address {tag, index}.
- MEM_WRITEDATA  out  32  block to write back; byte k occupies bits [8k+7:8k].
- MEM_READDATA  in  32  fetched block.
- MEM_BUSYWAIT  in  1  memory busy; a memory operation completes at the first rising edge where MEM_BUSYWAIT=0 and the request is still asserted.

Behaviour:
- Storage per block: data (32 bits), tag (3 bits), valid, dirty.
- hit = valid[index] && tag[index]==ADDRESS tag.
- FSM states: IDLE, WRITE_BACK, MEM_READ.
- Reset (RESET=1 at a rising edge):
  - state becomes IDLE; all valid and dirty bits are cleared; data and tag arrays are left unchanged.
  - Applies mid-operation too: an in-flight memory request is dropped the next cycle and dirty data is discarded.
  - Outputs after reset, with no request: BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READDATA=0.
- IDLE, no request: BUSYWAIT=0.
- IDLE, request and hit:
  - BUSYWAIT=0 combinationally in the same cycle.
  - Read: READDATA = the selected byte of the block, combinational, zero-cycle latency.
  - Write: the byte and the dirty bit are updated at the next rising edge.
  - The CPU advances on that same edge.
- IDLE, request and miss:
  - BUSYWAIT=1 combinationally.
  - Next state: WRITE_BACK if valid && dirty, else MEM_READ.
- WRITE_BACK:
  - MEM_WRITE=1, MEM_ADDRESS={stored tag, index}, MEM_WRITEDATA = the block data.
  - BUSYWAIT=1.
  - At the edge with MEM_BUSYWAIT=0, next state is MEM_READ.
- MEM_READ:
  - MEM_READ=1, MEM_ADDRESS={ADDRESS tag, index}, BUSYWAIT=1.
  - At the edge with MEM_BUSYWAIT=0: load MEM_READDATA into the block, set the tag, set valid=1, clear dirty; next state is IDLE.
  - The next cycle is then a hit and completes the pending access, so the stored byte is written in that cycle.
- MEM_READ and MEM_WRITE are never asserted together. Both are 0 in IDLE.
- READ and WRITE asserted together: treated as WRITE. READDATA is don't-care in that case.
- Dropping READ/WRITE while BUSYWAIT=1 is illegal; behaviour is undefined apart from the FSM finishing its current memory transaction.
- READDATA=0 whenever there is no IDLE hit.
- Latency:
  - Hit: 0 stall cycles.
  - Clean miss: 1 + Tm cycles, where Tm is the number of memory busy cycles plus 1.
  - Dirty miss: 1 + Tw + Tm cycles.

Test Plan:
1. RESET=1 for 2 cycles, then READ at ADDRESS=0x00 → BUSYWAIT=1 and MEM_READ=1 with MEM_ADDRESS=0x00. Memory returns 0x44332211 after 5 busy cycles → next cycle BUSYWAIT=0, READDATA=0x11. READ at 0x03 → READDATA=0x44 with no stall.
2. After scenario 1, WRITE 0xAB to 0x01 → no stall; block becomes dirty. READ 0x01 → READDATA=0xAB, no stall.
3. READ at 0x21 (same index 0, tag 1) on the dirty block → MEM_WRITE=1, MEM_ADDRESS=0x00, MEM_WRITEDATA=0x4433AB11. Then MEM_READ=1 with MEM_ADDRESS=0x08. Then hit, with READDATA = byte 1 of the fetched block.
4. WRITE 0x5A to 0xFE on a cold cache → fetch with MEM_ADDRESS=0x3F, then the byte is written. READ 0xFE → 0x5A. Evicting via 0x1E → write-back data has 0x5A in bits [23:16].
5. RESET asserted during MEM_READ with MEM_BUSYWAIT=1 → next cycle MEM_READ=0, BUSYWAIT=0, state IDLE. A later READ 0x00 misses (valid cleared).
6. READ and WRITE both asserted, hitting 0x02 with WRITEDATA=0x77 → byte updated to 0x77, dirty set, no memory traffic.
